// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD receive monitor.
package lcd_pkg;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned RGB_W = 24;
  localparam int unsigned CRC_W = 16;

  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } lcd_state_e;

  // One registered sample of the panel-side bus.
  typedef struct packed {
    logic             hd;
    logic             vd;
    logic             den;
    logic [RGB_W-1:0] rgb;
  } lcd_bus_t;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    return (v == {X_W{1'b1}}) ? v : v + X_W'(1);
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (v == {Y_W{1'b1}}) ? v : v + Y_W'(1);
  endfunction

endpackage

// File: rtl/lcd_rx_crc16.sv
// CRC-16-CCITT advance by one 24-bit pixel, MSB first (purely combinational).
module lcd_rx_crc16
  import lcd_pkg::*;
(
  input  logic [CRC_W-1:0] i_crc,
  input  logic [RGB_W-1:0] i_data,
  output logic [CRC_W-1:0] o_crc_c
);

  // Bit-serial LFSR unrolled across the whole pixel.
  always_comb begin
    logic [CRC_W-1:0] w_crc;
    logic             w_fb;
    w_crc = i_crc;
    w_fb  = 1'b0;
    for (int i = RGB_W - 1; i >= 0; i--) begin
      w_fb  = w_crc[CRC_W-1] ^ i_data[i];
      w_crc = {w_crc[CRC_W-2:0], 1'b0};
      if (w_fb) begin
        w_crc = w_crc ^ CRC_POLY;
      end
    end
    o_crc_c = w_crc;
  end

endmodule

// File: rtl/lcd_rx_monitor.sv
// Parallel RGB LCD receive monitor: recovers pixel coordinates, measures line
// and frame geometry against the expected panel size and qualifies lock.
// Optional per-frame CRC of pixel data is built when LCD_RX_CRC_EN is defined.
module lcd_rx_monitor
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             NCLK,
  input  logic             HD,
  input  logic             VD,
  input  logic             DEN,
  input  logic [7:0]       R,
  input  logic [7:0]       G,
  input  logic [7:0]       B,
  input  logic             err_clr,
  output logic             pix_valid,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic [RGB_W-1:0] pix_rgb,
  output logic             frame_done,
  output logic             locked,
  output logic             err_hsize,
  output logic             err_vsize,
  output logic [X_W-1:0]   meas_h,
  output logic [Y_W-1:0]   meas_v,
  output logic [CRC_W-1:0] frame_crc
);

  localparam int unsigned GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  lcd_bus_t    r_in;
  logic        r_nclk_q;
  logic        r_nclk_qq;
  logic        r_err_clr_q;
  logic        r_hd_p;
  logic        r_vd_p;
  logic        r_den_p;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic        r_bad;
  logic        r_abort;
  lcd_state_e  r_state;
  lcd_state_e  w_state_nxt;
  logic [GOOD_W-1:0] r_good_cnt;
  logic [GOOD_W-1:0] w_good_nxt;
  logic        w_frame_eval;

  logic        w_tick;
  logic        w_hd_fall;
  logic        w_vd_fall;
  logic        w_den_fall;
  logic        w_den_act;
  logic        w_trunc;
  logic        w_line_eval;
  logic        w_line_ok;
  logic        w_line_bad;
  logic        w_frame_bad;
  logic [X_W-1:0] w_x_cur;
  logic [X_W-1:0] w_x_nxt;
  logic [Y_W-1:0] w_y_line;
  logic [Y_W-1:0] w_y_cur;

  // Event decode, all qualified by the pixel-clock rising edge.
  assign w_tick      = r_nclk_q & ~r_nclk_qq;
  assign w_hd_fall   = w_tick & r_hd_p & ~r_in.hd;
  assign w_vd_fall   = w_tick & r_vd_p & ~r_in.vd;
  assign w_den_fall  = w_tick & r_den_p & ~r_in.den;
  assign w_den_act   = w_tick & r_in.den;
  // A sync edge inside a running DEN burst aborts that line.
  assign w_trunc     = (w_hd_fall | w_vd_fall) & r_den_p & r_in.den;
  assign w_line_eval = w_den_fall & ~r_abort;
  assign w_line_ok   = w_line_eval & (r_x == X_W'(H_ACTIVE));
  assign w_line_bad  = (w_line_eval & ~w_line_ok) | w_trunc;
  // Line completing on this tick counts before the frame is judged.
  assign w_y_line    = w_line_ok ? sat_inc_y(r_y) : r_y;
  assign w_frame_bad = r_bad | w_line_bad | (w_y_line != Y_W'(V_ACTIVE));
  assign w_x_cur     = w_hd_fall ? '0 : r_x;
  assign w_y_cur     = w_vd_fall ? '0 : w_y_line;

  // Column counter next value.
  always_comb begin
    w_x_nxt = w_x_cur;
    if (w_den_act) begin
      w_x_nxt = sat_inc_x(w_x_cur);
    end else if (w_line_ok) begin
      w_x_nxt = '0;
    end
  end

  // Input capture, counters, pixel strobe and error flags.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_in        <= '0;
      r_nclk_q    <= 1'b0;
      r_nclk_qq   <= 1'b0;
      r_err_clr_q <= 1'b0;
      r_hd_p      <= 1'b0;
      r_vd_p      <= 1'b0;
      r_den_p     <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_bad       <= 1'b0;
      r_abort     <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      err_hsize   <= 1'b0;
      err_vsize   <= 1'b0;
      meas_h      <= '0;
      meas_v      <= '0;
    end else begin
      r_in        <= {HD, VD, DEN, R, G, B};
      r_nclk_q    <= NCLK;
      r_nclk_qq   <= r_nclk_q;
      r_err_clr_q <= err_clr;
      pix_valid   <= w_den_act;
      frame_done  <= w_vd_fall & (r_state != S_SEARCH);
      if (w_tick) begin
        r_hd_p  <= r_in.hd;
        r_vd_p  <= r_in.vd;
        r_den_p <= r_in.den;
        r_x     <= w_x_nxt;
        r_y     <= w_y_cur;
        r_bad   <= w_vd_fall ? 1'b0 : (r_bad | w_line_bad);
        if (w_trunc) begin
          r_abort <= 1'b1;
        end else if (w_den_fall) begin
          r_abort <= 1'b0;
        end
      end
      if (w_den_act) begin
        pix_x   <= w_x_cur;
        pix_y   <= w_y_cur;
        pix_rgb <= r_in.rgb;
      end
      if (w_line_eval) begin
        meas_h <= r_x;
      end
      if (w_frame_eval) begin
        meas_v <= w_y_line;
      end
      if (w_line_bad) begin
        err_hsize <= 1'b1;
      end else if (r_err_clr_q) begin
        err_hsize <= 1'b0;
      end
      if (w_frame_eval && (w_y_line != Y_W'(V_ACTIVE))) begin
        err_vsize <= 1'b1;
      end else if (r_err_clr_q) begin
        err_vsize <= 1'b0;
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= S_SEARCH;
      r_good_cnt <= '0;
      locked     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      locked     <= (w_state_nxt == S_LOCKED);
    end
  end

  // Lock FSM next state: frames are judged only on VD falls after the first.
  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good_cnt;
    w_frame_eval = 1'b0;
    if (w_vd_fall) begin
      unique case (r_state)
        S_SEARCH: begin
          w_state_nxt = S_ACQUIRE;
          w_good_nxt  = '0;
        end
        S_ACQUIRE: begin
          w_frame_eval = 1'b1;
          if (w_frame_bad) begin
            w_good_nxt = '0;
          end else if ((r_good_cnt + GOOD_W'(1)) >= GOOD_W'(LOCK_FRAMES)) begin
            w_state_nxt = S_LOCKED;
            w_good_nxt  = GOOD_W'(LOCK_FRAMES);
          end else begin
            w_good_nxt = r_good_cnt + GOOD_W'(1);
          end
        end
        S_LOCKED: begin
          w_frame_eval = 1'b1;
          if (w_frame_bad) begin
            w_state_nxt = S_ACQUIRE;
            w_good_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = S_SEARCH;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

`ifdef LCD_RX_CRC_EN
  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_crc_base;
  logic [CRC_W-1:0] w_crc_upd;

  // Running CRC restarts at each VD fall; a pixel on that tick opens the new frame.
  assign w_crc_base = w_vd_fall ? CRC_INIT : r_crc;

  lcd_rx_crc16 u_crc (
    .i_crc   (w_crc_base),
    .i_data  (r_in.rgb),
    .o_crc_c (w_crc_upd)
  );

  // Running CRC and per-frame snapshot.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_crc     <= CRC_INIT;
      frame_crc <= '0;
    end else begin
      if (w_den_act) begin
        r_crc <= w_crc_upd;
      end else if (w_vd_fall) begin
        r_crc <= CRC_INIT;
      end
      if (w_vd_fall) begin
        frame_crc <= r_crc;
      end
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// Directed bench for lcd_rx_monitor with an 8x4 panel, lock after 2 frames,
// NCLK = CLK/2. Checks frame_crc against a local CRC model when LCD_RX_CRC_EN.
module tb_lcd_rx_monitor;

  logic        CLK;
  logic        RST_n;
  logic        NCLK;
  logic        HD;
  logic        VD;
  logic        DEN;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic        err_clr;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        frame_done;
  logic        locked;
  logic        err_hsize;
  logic        err_vsize;
  logic [10:0] meas_h;
  logic [9:0]  meas_v;
  logic [15:0] frame_crc;

  int n_chk;
  int n_err;
  int n_pix;
  int sum_x;
  int sum_y;
  int n_done;

  lcd_rx_monitor #(.H_ACTIVE(8), .V_ACTIVE(4), .LOCK_FRAMES(2)) dut (
    .CLK(CLK), .RST_n(RST_n), .NCLK(NCLK), .HD(HD), .VD(VD), .DEN(DEN),
    .R(R), .G(G), .B(B), .err_clr(err_clr),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .locked(locked), .err_hsize(err_hsize),
    .err_vsize(err_vsize), .meas_h(meas_h), .meas_v(meas_v), .frame_crc(frame_crc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe statistics sampled away from the active edge.
  always @(negedge CLK) begin
    if (pix_valid === 1'b1) begin
      n_pix = n_pix + 1;
      sum_x = sum_x + int'(pix_x);
      sum_y = sum_y + int'(pix_y);
    end
    if (frame_done === 1'b1) n_done = n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel period: NCLK low with new data, then NCLK high.
  task automatic px(input logic hd, input logic vd, input logic den, input logic [23:0] rgb);
    @(negedge CLK);
    NCLK = 1'b0; HD = hd; VD = vd; DEN = den; {R, G, B} = rgb;
    @(negedge CLK);
    NCLK = 1'b1;
  endtask

  task automatic line(input int n);
    px(1'b0, 1'b1, 1'b0, 24'h0);
    px(1'b1, 1'b1, 1'b0, 24'h0);
    repeat (n) px(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    px(1'b1, 1'b1, 1'b0, 24'h0);
    px(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic vd_start();
    px(1'b1, 1'b0, 1'b0, 24'h0);
    px(1'b1, 1'b1, 1'b0, 24'h0);
  endtask

  task automatic clr_pulse();
    @(negedge CLK); err_clr = 1'b1;
    @(negedge CLK); err_clr = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    logic        b;
    r = c;
    for (int i = 0; i < 24; i++) begin
      b = d[23-i] ^ r[15];
      r = (r << 1) ^ (b ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  initial begin
    int p0, sx0, sy0, d0;
    logic [15:0] gold;
    n_chk = 0; n_err = 0; n_pix = 0; sum_x = 0; sum_y = 0; n_done = 0;
    RST_n = 1'b0; NCLK = 1'b0; HD = 1'b1; VD = 1'b1; DEN = 1'b0;
    R = 8'h0; G = 8'h0; B = 8'h0; err_clr = 1'b0;
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;

    // Start a line, then reset in the middle of it.
    px(1'b1, 1'b1, 1'b0, 24'h0);
    px(1'b0, 1'b1, 1'b0, 24'h0);
    px(1'b1, 1'b1, 1'b0, 24'h0);
    repeat (3) px(1'b1, 1'b1, 1'b1, 24'h123456);
    @(negedge CLK);
    RST_n = 1'b0; DEN = 1'b0;
    @(negedge CLK);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_x", 32'(pix_x), 32'd0);
    chk("rst_pix_y", 32'(pix_y), 32'd0);
    chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_hsize", 32'(err_hsize), 32'd0);
    chk("rst_err_vsize", 32'(err_vsize), 32'd0);
    chk("rst_meas_h", 32'(meas_h), 32'd0);
    chk("rst_meas_v", 32'(meas_v), 32'd0);
    chk("rst_frame_crc", 32'(frame_crc), 32'd0);
    repeat (2) @(negedge CLK);
    RST_n = 1'b1;
    repeat (3) px(1'b1, 1'b1, 1'b0, 24'h0);

    // Frame 1: first VD only arms acquisition.
    p0 = n_pix; sx0 = sum_x; sy0 = sum_y; d0 = n_done;
    vd_start();
    repeat (4) line(8);
    chk("f1_pix_count", 32'(n_pix - p0), 32'd32);
    chk("f1_sum_x", 32'(sum_x - sx0), 32'd112);
    chk("f1_sum_y", 32'(sum_y - sy0), 32'd48);
    chk("f1_frame_done", 32'(n_done - d0), 32'd0);
    chk("f1_locked", 32'(locked), 32'd0);
    chk("f1_meas_h", 32'(meas_h), 32'd8);

    // Frame 2: first good frame judged.
    d0 = n_done;
    vd_start();
    repeat (4) line(8);
    chk("f2_frame_done", 32'(n_done - d0), 32'd1);
    chk("f2_meas_v", 32'(meas_v), 32'd4);
    chk("f2_locked", 32'(locked), 32'd0);

    // Frame 3: second good frame judged -> lock.
    vd_start();
    chk("f3_locked", 32'(locked), 32'd1);
    repeat (4) line(8);
    chk("f3_err_hsize", 32'(err_hsize), 32'd0);
    chk("f3_err_vsize", 32'(err_vsize), 32'd0);
    chk("f3_pix_rgb", 32'(pix_rgb), 32'hFFFFFF);
    gold = 16'hFFFF;
    for (int i = 0; i < 32; i++) gold = crc_px(gold, 24'hFFFFFF);
`ifdef LCD_RX_CRC_EN
    chk("f3_frame_crc", 32'(frame_crc), 32'(gold));
`else
    chk("f3_frame_crc", 32'(frame_crc), 32'd0);
`endif

    // Frame 4: one 7-pixel line while locked.
    vd_start();
    line(8);
    line(7);
    chk("short_err_hsize", 32'(err_hsize), 32'd1);
    chk("short_meas_h", 32'(meas_h), 32'd7);
    chk("short_locked", 32'(locked), 32'd1);
    line(8);
    line(8);

    // Frame 5: bad frame 4 drops lock; short line was not counted.
    vd_start();
    chk("f5_locked", 32'(locked), 32'd0);
    chk("f5_meas_v", 32'(meas_v), 32'd3);
    repeat (4) line(8);
    vd_start();
    chk("f6_locked", 32'(locked), 32'd0);
    repeat (4) line(8);
    vd_start();
    chk("f7_relocked", 32'(locked), 32'd1);
    clr_pulse();
    chk("f7_clr_err_hsize", 32'(err_hsize), 32'd0);
    chk("f7_clr_err_vsize", 32'(err_vsize), 32'd0);

    // Frame 7 carries 5 lines.
    repeat (5) line(8);
    vd_start();
    chk("v5_meas_v", 32'(meas_v), 32'd5);
    chk("v5_err_vsize", 32'(err_vsize), 32'd1);
    chk("v5_err_hsize", 32'(err_hsize), 32'd0);
    chk("v5_locked", 32'(locked), 32'd0);
    clr_pulse();
    chk("v5_clr_err_vsize", 32'(err_vsize), 32'd0);
    chk("v5_clr_err_hsize", 32'(err_hsize), 32'd0);

    // Frame 8: 3 lines, then VD and HD fall together mid-DEN.
    repeat (3) line(8);
    px(1'b0, 1'b1, 1'b0, 24'h0);
    px(1'b1, 1'b1, 1'b0, 24'h0);
    repeat (4) px(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    d0 = n_done;
    px(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
    px(1'b1, 1'b1, 1'b0, 24'h0);
    px(1'b1, 1'b1, 1'b0, 24'h0);
    px(1'b1, 1'b1, 1'b0, 24'h0);
    chk("trunc_frame_done", 32'(n_done - d0), 32'd1);
    chk("trunc_err_hsize", 32'(err_hsize), 32'd1);
    chk("trunc_meas_v", 32'(meas_v), 32'd3);
    chk("trunc_meas_h", 32'(meas_h), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
